// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings (MIPS funct) and FSM state type for alu_seq_core
package alu_pkg;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_seq_core_if.sv
// rtl/alu_seq_core_if.sv - load bus, start/ack handshake and result port bundle
// Flag outputs exist only when ALU_FLAGS_EN is defined.
interface alu_seq_core_if #(
  parameter int NB_DATA = 8
);
  logic [NB_DATA-1:0] i_data;
  logic               i_load_a;
  logic               i_load_b;
  logic               i_load_op;
  logic               i_start;
  logic               i_ack;
  logic               o_ready;
  logic               o_valid;
  logic [NB_DATA-1:0] o_result;
  logic               o_op_err;
`ifdef ALU_FLAGS_EN
  logic               o_zero;
  logic               o_neg;
  logic               o_carry;
  logic               o_ovf;
`endif

  modport master (
    output i_data, i_load_a, i_load_b, i_load_op, i_start, i_ack,
`ifdef ALU_FLAGS_EN
    input  o_zero, o_neg, o_carry, o_ovf,
`endif
    input  o_ready, o_valid, o_result, o_op_err
  );

  modport slave (
    input  i_data, i_load_a, i_load_b, i_load_op, i_start, i_ack,
`ifdef ALU_FLAGS_EN
    output o_zero, o_neg, o_carry, o_ovf,
`endif
    output o_ready, o_valid, o_result, o_op_err
  );

endinterface

// File: rtl/alu_datapath.sv
// rtl/alu_datapath.sv - combinational ALU over registered A/B/op
// Raw flags output {zero, neg, carry, ovf} exists only when ALU_FLAGS_EN is defined.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result,
`ifdef ALU_FLAGS_EN
  output logic [3:0]         o_flags,
`endif
  output logic               o_op_valid
);

  localparam int MSB = NB_DATA - 1;

  logic [NB_DATA:0]   add_ext;
  logic [NB_DATA:0]   sub_ext;
  logic               shift_over;
  logic [NB_DATA-1:0] srl_w;
  logic [NB_DATA-1:0] sra_w;

  assign add_ext    = {1'b0, i_a} + {1'b0, i_b};
  assign sub_ext    = {1'b0, i_a} - {1'b0, i_b};
  // Shift amounts of NB_DATA or more saturate instead of wrapping the shifter.
  assign shift_over = (i_b >= NB_DATA'(NB_DATA));
  assign srl_w      = shift_over ? '0 : (i_a >> i_b);
  assign sra_w      = shift_over ? {NB_DATA{i_a[MSB]}} : NB_DATA'($signed(i_a) >>> i_b);

  always_comb begin
    o_result   = '0;
    o_op_valid = 1'b1;
    case (i_op)
      NB_OP'(OP_ADD): o_result = add_ext[NB_DATA-1:0];
      NB_OP'(OP_SUB): o_result = sub_ext[NB_DATA-1:0];
      NB_OP'(OP_AND): o_result = i_a & i_b;
      NB_OP'(OP_OR):  o_result = i_a | i_b;
      NB_OP'(OP_XOR): o_result = i_a ^ i_b;
      NB_OP'(OP_NOR): o_result = ~(i_a | i_b);
      NB_OP'(OP_SRL): o_result = srl_w;
      NB_OP'(OP_SRA): o_result = sra_w;
      default:        o_op_valid = 1'b0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic carry;
  logic ovf;

  always_comb begin
    carry = 1'b0;
    ovf   = 1'b0;
    if (i_op == NB_OP'(OP_ADD)) begin
      carry = add_ext[NB_DATA];
      ovf   = (i_a[MSB] == i_b[MSB]) && (add_ext[MSB] != i_a[MSB]);
    end else if (i_op == NB_OP'(OP_SUB)) begin
      carry = sub_ext[NB_DATA];
      ovf   = (i_a[MSB] != i_b[MSB]) && (sub_ext[MSB] != i_a[MSB]);
    end
  end

  assign o_flags = {(o_result == '0), o_result[MSB], carry, ovf};
`else
  logic unused_carry;
  assign unused_carry = ^{add_ext[NB_DATA], sub_ext[NB_DATA]};
`endif

endmodule

// File: rtl/alu_seq_core.sv
// rtl/alu_seq_core.sv - sequential ALU: bus-loaded operands, start/valid/ack FSM, registered result
// Optional flag outputs enabled by ALU_FLAGS_EN.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic         clk,
  input  logic         i_rst_n,
  alu_seq_core_if.slave bus
);

  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] result_q, result_d;
  logic               op_err_q, op_err_d;
  logic               any_load;
  logic [NB_DATA-1:0] dp_result;
  logic               dp_op_valid;
`ifdef ALU_FLAGS_EN
  logic [3:0]         dp_flags;
  logic [3:0]         flags_q, flags_d;
`endif

  alu_datapath #(
    .NB_DATA (NB_DATA),
    .NB_OP   (NB_OP)
  ) u_datapath (
    .i_a        (a_q),
    .i_b        (b_q),
    .i_op       (op_q),
    .o_result   (dp_result),
`ifdef ALU_FLAGS_EN
    .o_flags    (dp_flags),
`endif
    .o_op_valid (dp_op_valid)
  );

  assign any_load = bus.i_load_a | bus.i_load_b | bus.i_load_op;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    op_err_d = op_err_q;
`ifdef ALU_FLAGS_EN
    flags_d  = flags_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.i_load_a)  a_d  = bus.i_data;
        if (bus.i_load_b)  b_d  = bus.i_data;
        if (bus.i_load_op) op_d = bus.i_data[NB_OP-1:0];
        // A load in the same cycle as start takes priority; start is dropped.
        if (bus.i_start && !any_load) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d  = ST_DONE;
        op_err_d = !dp_op_valid;
        if (dp_op_valid) begin
          result_d = dp_result;
`ifdef ALU_FLAGS_EN
          flags_d  = dp_flags;
`endif
        end
      end
      ST_DONE: begin
        if (bus.i_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
      op_err_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      op_err_q <= op_err_d;
`ifdef ALU_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign bus.o_ready  = (state_q == ST_IDLE);
  assign bus.o_valid  = (state_q == ST_DONE);
  assign bus.o_result = result_q;
  assign bus.o_op_err = op_err_q;
`ifdef ALU_FLAGS_EN
  assign {bus.o_zero, bus.o_neg, bus.o_carry, bus.o_ovf} = flags_q;
`endif

endmodule

// File: tb/tb_alu_seq_core.sv
// tb/tb_alu_seq_core.sv - scoreboard bench for alu_seq_core (NB_DATA=8); flag checks under ALU_FLAGS_EN
module tb_alu_seq_core;

  localparam logic [7:0] ADD = 8'h20, SUB = 8'h22, AND_ = 8'h24, OR_ = 8'h25;
  localparam logic [7:0] XOR_ = 8'h26, SRA = 8'h03, SRL = 8'h02, NOR_ = 8'h27, BAD = 8'h3F;
  localparam logic [2:0] LA = 3'b001, LB = 3'b010, LO = 3'b100;

  typedef struct packed {
    logic [7:0] res;
    logic       err;
    logic [3:0] flg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  bit   seen = 1'b0;
  exp_t exp_q[$];

  alu_seq_core_if #(.NB_DATA(8)) bus ();

  alu_seq_core #(.NB_DATA(8), .NB_OP(6)) dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (bus.o_valid) begin
      if (!seen) begin
        exp_t e;
        seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("sb_result", bus.o_result, e.res);
          check("sb_op_err", bus.o_op_err, e.err);
`ifdef ALU_FLAGS_EN
          check("sb_flags", {bus.o_zero, bus.o_neg, bus.o_carry, bus.o_ovf}, e.flg);
`endif
        end
      end
    end else begin
      seen = 1'b0;
    end
  end

  task automatic ld(input logic [2:0] which, input logic [7:0] d);
    bus.i_data    = d;
    bus.i_load_a  = which[0];
    bus.i_load_b  = which[1];
    bus.i_load_op = which[2];
    @(posedge clk); #1;
    bus.i_load_a  = 1'b0;
    bus.i_load_b  = 1'b0;
    bus.i_load_op = 1'b0;
  endtask

  task automatic ld3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    ld(LA, a);
    ld(LB, b);
    ld(LO, op);
  endtask

  task automatic run(input logic [7:0] r, input logic e, input logic [3:0] f);
    exp_q.push_back({r, e, f});
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    check("exec_no_valid", bus.o_valid, 0);
    check("exec_not_ready", bus.o_ready, 0);
    @(posedge clk); #1;
    check("done_valid", bus.o_valid, 1);
    bus.i_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_ack = 1'b0;
    check("ack_ready", bus.o_ready, 1);
    check("ack_drop_valid", bus.o_valid, 0);
  endtask

  initial begin
    bus.i_data = '0; bus.i_load_a = 0; bus.i_load_b = 0; bus.i_load_op = 0;
    bus.i_start = 0; bus.i_ack = 0;
    #12;
    check("rst_ready", bus.o_ready, 1);
    check("rst_valid", bus.o_valid, 0);
    check("rst_result", bus.o_result, 0);
    check("rst_op_err", bus.o_op_err, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // flags are {zero, neg, carry, ovf}
    ld3(8'h7F, 8'h01, ADD);     run(8'h80, 0, 4'b0101);
    ld3(8'h03, 8'h05, SUB);     run(8'hFE, 0, 4'b0110);
    ld(LA | LB, 8'h05);         run(8'h00, 0, 4'b1000);
    ld3(8'h90, 8'h02, SRA);     run(8'hE4, 0, 4'b0100);
    ld(LO, SRL);                run(8'h24, 0, 4'b0000);
    ld(LB, 8'h09);              run(8'h00, 0, 4'b1000);
    ld(LO, SRA);                run(8'hFF, 0, 4'b0100);
    ld3(8'hF0, 8'h3C, AND_);    run(8'h30, 0, 4'b0000);
    ld(LO, NOR_);               run(8'h03, 0, 4'b0000);
    ld(LO, XOR_);               run(8'hCC, 0, 4'b0100);

    ld3(8'h90, 8'h02, SRL);     run(8'h24, 0, 4'b0000);
    ld(LO, BAD);                run(8'h24, 1, 4'b0000);
    ld(LO, ADD);                run(8'h92, 0, 4'b0100);

    // load and start together: start must be dropped
    bus.i_data = 8'h01; bus.i_load_b = 1'b1; bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_load_b = 1'b0; bus.i_start = 1'b0;
    check("load_beats_start", bus.o_ready, 1);
    @(posedge clk); #1;
    check("load_beats_start_novalid", bus.o_valid, 0);

    // DONE hold with ack low while loads/start are pulsed
    ld3(8'h10, 8'h20, OR_);
    exp_q.push_back({8'h30, 1'b0, 4'b0000});
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      bus.i_data = 8'hAA; bus.i_load_a = 1'b1; bus.i_start = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", bus.o_valid, 1);
      check("hold_result", bus.o_result, 8'h30);
    end
    bus.i_load_a = 1'b0; bus.i_start = 1'b0; bus.i_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_ack = 1'b0;
    check("hold_release_ready", bus.o_ready, 1);
    ld(LO, SUB);                run(8'hF0, 0, 4'b0110);

    // asynchronous reset while in EXEC
    ld3(8'h01, 8'h01, ADD);
    bus.i_start = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", bus.o_valid, 0);
    check("arst_result", bus.o_result, 0);
    check("arst_ready", bus.o_ready, 1);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("arst_no_result", bus.o_valid, 0);
    end
    check("arst_result_kept0", bus.o_result, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
